// File: rtl/ray_pkg.sv
// ray_pkg: shared state encoding, widths and ray payload for the dispatch scheduler
package ray_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} sched_state_t;
    localparam int DIR_W = 32;
    localparam int RAY_IDX_W = 32;
    typedef struct packed {
        logic [RAY_IDX_W-1:0] index;
        logic [DIR_W-1:0]     dir_x;
        logic [DIR_W-1:0]     dir_y;
        logic [DIR_W-1:0]     dir_z;
    } ray_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or above rr_ptr_i, with wrap
module rr_arbiter #(
    parameter int NUM_UNITS = 4,
    parameter int PTR_W     = $clog2(NUM_UNITS)
) (
    input  logic [NUM_UNITS-1:0] req_i,
    input  logic [PTR_W-1:0]     rr_ptr_i,
    output logic [NUM_UNITS-1:0] grant_o,
    output logic                 grant_valid_o
);
    logic [NUM_UNITS-1:0] hi_mask, hi_req, pick;
    // Requests at or above the pointer win; otherwise wrap to the lowest request overall.
    always_comb begin
        hi_mask = ~((NUM_UNITS'(1) << rr_ptr_i) - NUM_UNITS'(1));
        hi_req  = req_i & hi_mask;
        pick    = |hi_req ? hi_req : req_i;
        grant_o = pick & (~pick + NUM_UNITS'(1));
    end
    assign grant_valid_o = |req_i;
endmodule

// File: rtl/ray_dispatch_scheduler.sv
// ray_dispatch_scheduler: frame controller feeding generated rays to a pool of tracer units
module ray_dispatch_scheduler
    import ray_pkg::*;
#(
    parameter int NUM_UNITS = 4,
    parameter int IDX_W     = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [12:0]          image_width,
    input  logic [12:0]          image_height,
    output logic                 gen_enable,
    input  logic                 gen_valid,
    output logic                 gen_ready,
    input  logic [IDX_W-1:0]     gen_index,
    input  logic [DIR_W-1:0]     gen_dir_x,
    input  logic [DIR_W-1:0]     gen_dir_y,
    input  logic [DIR_W-1:0]     gen_dir_z,
    output logic [NUM_UNITS-1:0] unit_valid,
    output logic [IDX_W-1:0]     unit_index,
    output logic [DIR_W-1:0]     unit_dir_x,
    output logic [DIR_W-1:0]     unit_dir_y,
    output logic [DIR_W-1:0]     unit_dir_z,
    input  logic [NUM_UNITS-1:0] unit_idle,
    input  logic [NUM_UNITS-1:0] unit_done,
    output logic                 frame_busy,
    output logic                 frame_done,
    output logic                 err_spurious
);
    localparam int PTR_W = $clog2(NUM_UNITS);
    sched_state_t         state_q, state_d;
    logic [NUM_UNITS-1:0] busy_q, busy_d, uv_q, uv_d, avail, grant, fin;
    logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d, grant_idx;
    logic [IDX_W-1:0]     total_q, total_d, disp_q, disp_d, comp_q, comp_d, fin_cnt;
    logic                 err_q, err_d, grant_valid, start_acc, fire;
    ray_t                 ray_q, ray_d, ray_in;

    // avail uses the pre-completion busy mask, so a unit finishing now is grantable next cycle
    assign avail     = unit_idle & ~busy_q;
    assign fin       = unit_done & busy_q;
    assign start_acc = start && state_q == IDLE;
    assign gen_ready = state_q == RUN && disp_q < total_q && grant_valid;
    assign fire      = gen_valid && gen_ready;
    assign ray_in    = '{index: RAY_IDX_W'(gen_index), dir_x: gen_dir_x, dir_y: gen_dir_y, dir_z: gen_dir_z};

    rr_arbiter #(.NUM_UNITS(NUM_UNITS), .PTR_W(PTR_W)) u_arb (
        .req_i        (avail),
        .rr_ptr_i     (rr_ptr_q),
        .grant_o      (grant),
        .grant_valid_o(grant_valid)
    );

    always_comb begin
        grant_idx = '0;
        fin_cnt   = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            if (grant[i]) grant_idx = PTR_W'(i);
            if (fin[i]) fin_cnt = fin_cnt + 1'b1;
        end
    end

    always_comb begin
        total_d  = start_acc ? IDX_W'(image_width) * IDX_W'(image_height) : total_q;
        disp_d   = start_acc ? '0 : disp_q + IDX_W'(fire);
        comp_d   = start_acc ? '0 : comp_q + fin_cnt;
        busy_d   = (busy_q & ~unit_done) | (fire ? grant : '0);
        rr_ptr_d = !fire ? rr_ptr_q : grant_idx == PTR_W'(NUM_UNITS - 1) ? '0 : grant_idx + 1'b1;
        err_d    = (err_q & ~start_acc) | |(unit_done & ~busy_q);
        uv_d     = fire ? grant : '0;
        ray_d    = fire ? ray_in : ray_q;
        state_d  = state_q == IDLE  ? (start ? (total_d == '0 ? DONE : RUN) : IDLE) :
                   state_q == RUN   ? (disp_q == total_q ? DRAIN : RUN) :
                   state_q == DRAIN ? (comp_q == total_q ? DONE : DRAIN) : IDLE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            busy_q   <= '0;
            uv_q     <= '0;
            rr_ptr_q <= '0;
            total_q  <= '0;
            disp_q   <= '0;
            comp_q   <= '0;
            err_q    <= 1'b0;
            ray_q    <= '0;
        end else begin
            state_q  <= state_d;
            busy_q   <= busy_d;
            uv_q     <= uv_d;
            rr_ptr_q <= rr_ptr_d;
            total_q  <= total_d;
            disp_q   <= disp_d;
            comp_q   <= comp_d;
            err_q    <= err_d;
            ray_q    <= ray_d;
        end
    end

    assign gen_enable   = state_q == RUN;
    assign frame_busy   = state_q != IDLE;
    assign frame_done   = state_q == DONE;
    assign err_spurious = err_q;
    assign unit_valid   = uv_q;
    assign unit_index   = IDX_W'(ray_q.index);
    assign unit_dir_x   = ray_q.dir_x;
    assign unit_dir_y   = ray_q.dir_y;
    assign unit_dir_z   = ray_q.dir_z;
endmodule

// File: doc/ray_dispatch_scheduler.md
Name: ray_dispatch_scheduler

Overview:
Frame-level controller between the ray generator and a pool of NUM_UNITS ray-tracer units.
- Starts a frame and gates the ray generator.
- Takes one generated ray per cycle through a valid/ready handshake.
- Sends each ray to an idle tracer unit, using round-robin arbitration.
- Counts dispatched and completed rays, and signals frame completion.

Parameters:
NUM_UNITS, 4, number of tracer units in the pool (2..16)
IDX_W, 32, width of the pixel index and of the frame counters

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse that begins a frame
image_width  in  13  pixels per row, sampled at start
image_height  in  13  rows per frame, sampled at start
gen_enable  out  1  high while the generator may produce rays (state RUN)
gen_valid  in  1  generator has a ray
gen_ready  out  1  scheduler accepts the ray this cycle
gen_index  in  IDX_W  pixel index of the ray
gen_dir_x/y/z  in  32 each  ray direction
unit_valid  out  NUM_UNITS  one-hot, one-cycle dispatch strobe
unit_index  out  IDX_W  broadcast pixel index
unit_dir_x/y/z  out  32 each  broadcast ray direction
unit_idle  in  NUM_UNITS  per-unit "can take a ray"
unit_done  in  NUM_UNITS  per-unit one-cycle completion pulse
frame_busy  out  1  high from start until frame_done
frame_done  out  1  one-cycle pulse when every pixel has completed
err_spurious  out  1  sticky; set by a unit_done with no outstanding ray

Behaviour:
- Reset values: all outputs 0; state IDLE; busy_q=0; rr_ptr=0; counters=0.
- total = image_width*image_height, IDX_W bits wide, latched on accepted start.
- States:
  - IDLE: start -> latch total, clear counters.
    - total==0 -> DONE; otherwise -> RUN.
    - start while not in IDLE is ignored.
  - RUN:
    - gen_enable=1.
    - Moves to DRAIN in the cycle after dispatched reaches total.
  - DRAIN:
    - gen_enable=0, gen_ready=0.
    - Moves to DONE when completed==total.
  - DONE:
    - frame_done=1 for exactly one cycle, then -> IDLE.
    - frame_busy falls together with leaving DONE.
- Availability mask: avail = unit_idle & ~busy_q.
- gen_ready (combinational) = (state==RUN) & (dispatched<total) & |avail.
- Dispatch on gen_valid & gen_ready:
  - Grant = first set bit of avail, searching from rr_ptr upward with wrap.
  - Registered outputs in the next cycle: unit_valid=onehot(grant); unit_index/unit_dir_* = the accepted values.
  - Latency: exactly 1 cycle from handshake to strobe.
  - busy_q[grant] set; dispatched+1; rr_ptr = grant+1 mod NUM_UNITS.
  - Without a handshake, unit_valid=0 and unit_index/unit_dir_* hold their last values.
- Completion, for each unit i with unit_done[i]:
  - busy_q[i] set -> clear busy_q[i]; completed increments by popcount(unit_done & busy_q), so multiple completions in one cycle are allowed.
  - busy_q[i] clear -> set err_spurious; counters unchanged.
- Simultaneous events:
  - Done on unit i plus a dispatch in the same cycle: the grant cannot be i, because avail used the old busy_q. unit i becomes grantable next cycle.
  - The final dispatch and a completion in the same cycle are both counted.
- Counters never exceed total; gen_valid arriving after dispatched==total is never accepted.
- Async reset mid-frame: immediate return to the reset values. In-flight rays are abandoned; results from units after reset are treated as spurious.
- err_spurious is cleared only by reset or by an accepted start.

Decomposition:
- Shared package ray_pkg:
  - sched_state_t enum {IDLE, RUN, DRAIN, DONE};
  - DIR_W=32 constant;
  - ray_t struct {index, dir_x, dir_y, dir_z}.
- Sub-module rr_arbiter (NUM_UNITS param):
  - inputs: req mask, rr_ptr;
  - outputs: one-hot grant, grant_valid;
  - purely combinational.

Test Plan:
1. Frame 4x2, 4 always-idle units, gen_valid=1, each unit's done 3 cycles after its dispatch -> 8 dispatches with grants u0,u1,u2,u3,u0..., unit_index 0..7 in order; one frame_done; frame_busy low after it.
2. Backpressure: unit_idle=0 for 5 cycles in RUN -> gen_ready=0, no unit_valid. Release unit 2 only -> next dispatch grant=u2 and rr_ptr=3.
3. image_width=0 with start -> DONE next cycle, frame_done pulse, gen_enable never high.
4. Units 1 and 3 done in the same cycle, both busy -> completed increments by 2; the following dispatch may grant u1 or u3, rr_ptr order.
5. unit_done[0] while unit 0 is not busy -> err_spurious=1, completed unchanged; the next start clears it.
6. reset_n asserted low mid-RUN after 3 dispatches -> all outputs 0 asynchronously. A new start of a 2x2 frame completes with exactly 4 dispatches.
